operand_entry: RTL and testbench

Serial decimal operand-entry engine for the Basys-3 calculator datapath. It accepts debounced keypad codes one at a time and builds up to `NUM_OPS` binary operands of up to `DIGITS` decimal digits each, using a multiply-by-10 accumulate. When the last operand is entered, it presents all operands to the ALU stage with a valid/ready handshake. It replaces fixed two-digit, two-operand BCD packing with parametrised, stateful entry that supports overflow protection and clear.

---
 rtl/operand_entry_pkg.sv | 19 +
 rtl/operand_entry_if.sv | 28 ++
 rtl/operand_entry_dec_mac10.sv | 11 +
 rtl/operand_entry.sv | 136 +++++++++++++
 tb/tb_operand_entry.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/operand_entry_pkg.sv
// Shared key codes, FSM states and sizing helpers for the serial decimal operand-entry engine.
package operand_entry_pkg;

   localparam logic [3:0] KEY_ENTER = 4'd10;
   localparam logic [3:0] KEY_CLEAR = 4'd11;
   localparam logic [3:0] KEY_SIGN  = 4'd12;

   typedef enum logic [1:0] {
      ENTRY,
      UPDATE,
      DONE
   } state_e;

   // Width of the operand index; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/operand_entry_if.sv
// Keypad-in / operand-set-out handshake bundle for operand_entry.
interface operand_entry_if
   import operand_entry_pkg::*;
#(
   parameter int unsigned NUM_OPS = 2,
   parameter int unsigned W       = 8
);
   localparam int unsigned IW = idx_w(NUM_OPS);

   logic                 key_valid;
   logic [3:0]           key_code;
   logic                 key_ready;
   logic                 op_valid;
   logic                 op_ready;
   logic [NUM_OPS*W-1:0] ops;
   logic [IW-1:0]        op_idx;
   logic                 digit_ovf;

   modport master (
      output key_valid, key_code, op_ready,
      input  key_ready, op_valid, ops, op_idx, digit_ovf
   );

   modport slave (
      input  key_valid, key_code, op_ready,
      output key_ready, op_valid, ops, op_idx, digit_ovf
   );
endinterface

// File: rtl/operand_entry_dec_mac10.sv
// Combinational decimal accumulate acc*10 + digit via shift-add, truncated to W bits.
module dec_mac10 #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] acc,
   input  logic [3:0]   digit,
   output logic [W-1:0] res
);
   // Sum formed in W+4 bits; the parent's width check guarantees no loss on truncation.
   assign res = W'(({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{W{1'b0}}, digit});
endmodule

// File: rtl/operand_entry.sv
// Serial keypad operand builder with valid/ready hand-off of NUM_OPS operands.
// Optional macro OPERAND_ENTRY_SIGN_EN enables per-operand sign toggling with key 12.
module operand_entry
   import operand_entry_pkg::*;
#(
   parameter int unsigned NUM_OPS = 2,
   parameter int unsigned DIGITS  = 2,
   parameter int unsigned W       = 8
) (
   input  logic            clk,
   input  logic            rst,
   operand_entry_if.slave  bus
);
   localparam int unsigned CW = $clog2(DIGITS + 1);
   localparam int unsigned IW = idx_w(NUM_OPS);
`ifdef OPERAND_ENTRY_SIGN_EN
   localparam int unsigned SGN = 1;
`else
   localparam int unsigned SGN = 0;
`endif

   if (W < $clog2(10**DIGITS) + SGN) begin : g_width_chk
      $error("operand_entry: W too small for DIGITS");
   end

   state_e        state;
   logic [W-1:0]  opr [NUM_OPS];
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [3:0]    digit;
   logic          ovf;
   logic          krdy;
   logic          ovld;
   logic [W-1:0]  mac;
   logic          clr_c;
`ifdef OPERAND_ENTRY_SIGN_EN
   logic [NUM_OPS-1:0] sgn;
`endif

   dec_mac10 #(.W(W)) u_mac (
      .acc   (opr[idx]),
      .digit (digit),
      .res   (mac)
   );

   // Operand-set wipe: explicit CLEAR key or completed hand-off.
   assign clr_c = (state == ENTRY && bus.key_valid && bus.key_code == KEY_CLEAR) ||
                  (state == DONE && bus.op_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ENTRY;
         for (int k = 0; k < NUM_OPS; k++) opr[k] <= '0;
         cnt   <= '0;
         idx   <= '0;
         digit <= '0;
         ovf   <= 1'b0;
         krdy  <= 1'b1;
         ovld  <= 1'b0;
`ifdef OPERAND_ENTRY_SIGN_EN
         sgn   <= '0;
`endif
      end else begin
         case (state)
            ENTRY: begin
               if (bus.key_valid) begin
                  if (bus.key_code < KEY_ENTER) begin
                     if (cnt == CW'(DIGITS)) begin
                        ovf <= 1'b1;
                     end else begin
                        digit <= bus.key_code;
                        state <= UPDATE;
                        krdy  <= 1'b0;
                     end
                  end else if (bus.key_code == KEY_ENTER) begin
                     cnt <= '0;
                     if (idx == IW'(NUM_OPS - 1)) begin
                        state <= DONE;
                        krdy  <= 1'b0;
                        ovld  <= 1'b1;
`ifdef OPERAND_ENTRY_SIGN_EN
                        for (int k = 0; k < NUM_OPS; k++)
                           if (sgn[k]) opr[k] <= -opr[k];
`endif
                     end else begin
                        idx <= idx + IW'(1);
                     end
`ifdef OPERAND_ENTRY_SIGN_EN
                  end else if (bus.key_code == KEY_SIGN) begin
                     sgn[idx] <= ~sgn[idx];
`endif
                  end
               end
            end
            UPDATE: begin
               opr[idx] <= mac;
               cnt      <= cnt + CW'(1);
               state    <= ENTRY;
               krdy     <= 1'b1;
            end
            DONE: begin
               if (bus.op_ready) begin
                  state <= ENTRY;
                  krdy  <= 1'b1;
                  ovld  <= 1'b0;
               end
            end
            default: begin
               state <= ENTRY;
               krdy  <= 1'b1;
               ovld  <= 1'b0;
            end
         endcase

         if (clr_c) begin
            for (int k = 0; k < NUM_OPS; k++) opr[k] <= '0;
            cnt <= '0;
            idx <= '0;
            ovf <= 1'b0;
`ifdef OPERAND_ENTRY_SIGN_EN
            sgn <= '0;
`endif
         end
      end
   end

   for (genvar k = 0; k < NUM_OPS; k++) begin : g_ops
      assign bus.ops[k*W +: W] = opr[k];
   end

   assign bus.key_ready = krdy;
   assign bus.op_valid  = ovld;
   assign bus.op_idx    = idx;
   assign bus.digit_ovf = ovf;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed scenarios plus random key streams against a transaction-level model.
module tb_operand_entry;
   localparam int unsigned NUM_OPS = 2;
   localparam int unsigned DIGITS  = 2;
   localparam int unsigned W       = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   int   mval [NUM_OPS];
   bit   msgn [NUM_OPS];
   int   mcnt, midx;
   bit   movf, mdone;

   operand_entry_if #(.NUM_OPS(NUM_OPS), .W(W)) bus ();

   operand_entry #(.NUM_OPS(NUM_OPS), .DIGITS(DIGITS), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < NUM_OPS; k++) begin
         mval[k] = 0;
         msgn[k] = 1'b0;
      end
      mcnt = 0; midx = 0; movf = 1'b0; mdone = 1'b0;
   endtask

   // Effect of one accepted key on the operand set, in plain integer arithmetic.
   task automatic model_key(input int c);
      if (c <= 9) begin
         if (mcnt < DIGITS) begin
            mval[midx] = mval[midx] * 10 + c;
            mcnt++;
         end else begin
            movf = 1'b1;
         end
      end else if (c == 10) begin
         if (midx < NUM_OPS - 1) begin
            midx++;
            mcnt = 0;
         end else begin
            mdone = 1'b1;
         end
      end else if (c == 11) begin
         model_clear();
`ifdef OPERAND_ENTRY_SIGN_EN
      end else if (c == 12) begin
         msgn[midx] = !msgn[midx];
`endif
      end
   endtask

   function automatic logic [NUM_OPS*W-1:0] exp_ops();
      logic [NUM_OPS*W-1:0] e;
      int v;
      for (int k = 0; k < NUM_OPS; k++) begin
         v = mval[k];
         if (mdone && msgn[k]) v = -v;
         e[k*W +: W] = W'(v);
      end
      return e;
   endfunction

   task automatic chk_state(input string tag);
      chk({tag, "_ops"},   64'(bus.ops),   64'(exp_ops()));
      chk({tag, "_idx"},   64'(bus.op_idx), 64'(midx));
      chk({tag, "_ovf"},   64'(bus.digit_ovf), 64'(movf));
      chk({tag, "_valid"}, 64'(bus.op_valid),  64'(mdone));
      chk({tag, "_kr"},    64'(bus.key_ready), 64'(!mdone));
   endtask

   // Present a key once key_ready is high; returns after the accepting edge.
   task automatic send(input logic [3:0] c);
      int n = 0;
      while (bus.key_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("kr_wait", 64'(bus.key_ready), 64'd1);
      bus.key_valid = 1'b1;
      bus.key_code  = c;
      @(negedge clk);
      bus.key_valid = 1'b0;
   endtask

   task automatic press(input logic [3:0] c);
      bit upd;
      upd = (c <= 4'd9) && (mcnt < DIGITS) && !mdone;
      send(c);
      model_key(int'(c));
      if (upd) begin
         chk("upd_kr", 64'(bus.key_ready), 64'd0);
         @(negedge clk);
      end
      chk_state($sformatf("key%0d", c));
   endtask

   // Hold the consumer off for some cycles with a pending key, then complete the hand-off.
   task automatic take(input int hold);
      logic [NUM_OPS*W-1:0] snap;
      chk("take_valid", 64'(bus.op_valid), 64'd1);
      snap = bus.ops;
      bus.key_valid = 1'b1;
      bus.key_code  = 4'd3;
      repeat (hold) begin
         @(negedge clk);
         chk("hold_ops",   64'(bus.ops), 64'(snap));
         chk("hold_kr",    64'(bus.key_ready), 64'd0);
         chk("hold_valid", 64'(bus.op_valid), 64'd1);
      end
      bus.op_ready = 1'b1;
      @(negedge clk);
      bus.op_ready  = 1'b0;
      bus.key_valid = 1'b0;
      model_clear();
      chk_state("post_hs");
   endtask

   initial begin
      int r, guard;
      logic [3:0] c;
      rst = 1'b1;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'd0;
      bus.op_ready  = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_state("reset");

      // Two operands, 47 and 9.
      press(4'd4); press(4'd7); press(4'd10); press(4'd9); press(4'd10);
      chk("ops_47_9", 64'(bus.ops), 64'h092F);
      take(0);

      // Third digit dropped, overflow sticky.
      press(4'd9); press(4'd9); press(4'd5);
      chk("ovf_op0", 64'(bus.ops[7:0]), 64'd99);
      chk("ovf_flag", 64'(bus.digit_ovf), 64'd1);
      press(4'd10);
      chk("ovf_idx", 64'(bus.op_idx), 64'd1);
      press(4'd10);
      chk("ovf_in_done", 64'(bus.digit_ovf), 64'd1);
      take(1);

      // CLEAR then empty operands, with a stalled consumer.
      press(4'd3); press(4'd11); press(4'd10); press(4'd10);
      chk("clr_ops", 64'(bus.ops), 64'd0);
      chk("clr_valid", 64'(bus.op_valid), 64'd1);
      chk("clr_ovf", 64'(bus.digit_ovf), 64'd0);
      take(5);
      chk("hs_ops_zero", 64'(bus.ops), 64'd0);

      // Reset while an accumulate is pending.
      press(4'd2);
      send(4'd6);
      chk("rst_upd_kr", 64'(bus.key_ready), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      chk_state("rst_upd");

`ifdef OPERAND_ENTRY_SIGN_EN
      press(4'd1); press(4'd2); press(4'd12); press(4'd10); press(4'd5); press(4'd10);
      chk("sign_op0", 64'(bus.ops[7:0]), 64'hF4);
      chk("sign_op1", 64'(bus.ops[15:8]), 64'd5);
      take(2);
`endif

      // Random key streams, including reserved and sign codes.
      for (int t = 0; t < 12; t++) begin
         guard = 0;
         while (!mdone && guard < 40) begin
            r = int'($urandom_range(0, 99));
            if (r < 65)      c = 4'($urandom_range(0, 9));
            else if (r < 83) c = 4'd10;
            else if (r < 87) c = 4'd11;
            else if (r < 93) c = 4'd12;
            else             c = 4'($urandom_range(13, 15));
            press(c);
            guard++;
         end
         while (!mdone) press(4'd10);
         take(int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
